// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller that steps a small ALU datapath (bitwise invert plus
// adder) through ADD, SUB, NEG and shift-add MUL sequences.
// Operations are requested over one valid/ready handshake.
// Results are returned over a second valid/ready handshake.
//
// Optional feature macro: OVERFLOW_FLAG_EN
//   When defined, the rsp_ovf output is present. It is a signed-overflow flag
//   for ADD/SUB/NEG and a copy of the carry flag for MUL.
//   When undefined, the port and its logic are absent.

module alu_op_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             rsp_ovf
`endif
);

  // Opcode encoding of req_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  // Counter wide enough to hold WIDTH (the number of MUL steps)
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

  state_e               state_q, state_d;

  // Adder operands and carry-in
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 cin_q, cin_d;

  // Shift-add multiplier state
  // The multiplier bits live in b_q and are shifted right once per step.
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Registered response
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
`ifdef OVERFLOW_FLAG_EN
  logic                 ovf_q, ovf_d;
`endif

  // Datapath helpers shared by the next-state logic
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // Adder: (WIDTH+1)-bit sum of the current operands and carry-in
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  end

  // Multiplier step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_next = acc_q + (b_q[0] ? a_sh_q : {(2*WIDTH){1'b0}});
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      a_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      a_sh_q   <= a_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state and datapath sequencing; every register holds unless its state updates it
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    a_sh_d   = a_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_ADD: begin
              a_d     = req_a;
              b_d     = req_b;
              cin_d   = 1'b0;
              state_d = S_EXEC;
            end
            OP_SUB: begin
              a_d     = req_a;
              b_d     = req_b;
              cin_d   = 1'b0;
              state_d = S_INV;
            end
            OP_NEG: begin
              // -a is computed as 0 + ~a + 1
              a_d     = '0;
              b_d     = req_a;
              cin_d   = 1'b0;
              state_d = S_INV;
            end
            OP_MUL: begin
              a_sh_d  = {{WIDTH{1'b0}}, req_a};
              b_d     = req_b;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_MUL;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_INV: begin
        // Two's complement subtrahend: invert now and add one through carry-in
        b_d     = ~b_q;
        cin_d   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
`ifdef OVERFLOW_FLAG_EN
        // Signed overflow: operand signs agree but the result sign differs
        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
        state_d  = S_DONE;
      end

      S_MUL: begin
        acc_d  = acc_next;
        a_sh_d = a_sh_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // The last partial product is taken from acc_next, so the final add is included
          result_d = acc_next[WIDTH-1:0];
          carry_d  = |acc_next[2*WIDTH-1:WIDTH];
`ifdef OVERFLOW_FLAG_EN
          ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
`endif
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        // The response is held until it is taken, then the sequencer returns to idle.
        // No request is accepted in the same cycle.
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state; result flags come straight from registers
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    rsp_result = result_q;
    rsp_carry  = carry_q;
`ifdef OVERFLOW_FLAG_EN
    rsp_ovf    = ovf_q;
`endif
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer at WIDTH=3.
// It runs directed operations followed by random ones.
// Expected values come from an arithmetic model of each operation.
// Define OVERFLOW_FLAG_EN to include the rsp_ovf port and its checks.

module tb_alu_op_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         busy;
`ifdef OVERFLOW_FLAG_EN
  logic         rsp_ovf;
`endif

  int checkCount = 0;
  int errorCount = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Global time limit so a stuck design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and count the comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Arithmetic reference: result, flags and latency of one operation
  function automatic void refModel(input logic [1:0] op, input int a, input int b,
                                   output int res, output int car, output int ovf, output int lat);
    int sa, sb, sv, p;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sv = 0;
    case (op)
      2'b00: begin
        res = (a + b) & ((1 << W) - 1);
        car = ((a + b) >= (1 << W)) ? 1 : 0;
        sv  = sa + sb;
        lat = 2;
      end
      2'b01: begin
        res = (a - b) & ((1 << W) - 1);
        car = (a >= b) ? 1 : 0;
        sv  = sa - sb;
        lat = 3;
      end
      2'b11: begin
        res = (-a) & ((1 << W) - 1);
        car = (a == 0) ? 1 : 0;
        sv  = -sa;
        lat = 3;
      end
      default: begin
        p   = a * b;
        res = p & ((1 << W) - 1);
        car = (p >= (1 << W)) ? 1 : 0;
        lat = W + 1;
      end
    endcase
    if (op == 2'b10) ovf = car;
    else ovf = (sv > (1 << (W-1)) - 1 || sv < -(1 << (W-1))) ? 1 : 0;
  endfunction

  // Run one full request/response transaction with `stall` cycles of back-pressure
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int stall);
    int expRes, expCar, expOvf, expLat, cycles;
    refModel(op, int'(a), int'(b), expRes, expCar, expOvf, expLat);

    cycles = 0;
    while (!req_ready && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("req_ready before accept", req_ready, 1);

    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    checkOutput("busy after accept", busy, 1);

    cycles = 1;
    while (!rsp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      req_a = W'($urandom);
      req_b = W'($urandom);
    end
    checkOutput("latency", cycles, expLat);
    checkOutput("result", rsp_result, expRes);
    checkOutput("carry", rsp_carry, expCar);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("ovf", rsp_ovf, expOvf);
`endif

    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom_range(0, 1)) | (i == 1);
      @(posedge clk); #1;
      checkOutput("held rsp_valid", rsp_valid, 1);
      checkOutput("held result", rsp_result, expRes);
      checkOutput("held carry", rsp_carry, expCar);
      checkOutput("req_ready while done", req_ready, 0);
    end

    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid after retire", rsp_valid, 0);
    checkOutput("no accept in handshake cycle", busy, 0);
  endtask

  // Main sequence: reset, directed cases, reset abort, random traffic
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset result", rsp_result, 0);
    checkOutput("reset carry", rsp_carry, 0);
    checkOutput("reset busy", busy, 0);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("reset ovf", rsp_ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed operations");
    applyStimulus(2'b00, 3'd3, 3'd2, 0);
    applyStimulus(2'b01, 3'd2, 3'd3, 0);
    applyStimulus(2'b01, 3'd3, 3'd3, 0);
    applyStimulus(2'b10, 3'd3, 3'd3, 0);
    applyStimulus(2'b10, 3'd2, 3'd3, 0);
    applyStimulus(2'b00, 3'd1, 3'd1, 5);
    applyStimulus(2'b11, 3'd0, 3'd5, 0);
    applyStimulus(2'b00, 3'd3, 3'd1, 0);
    applyStimulus(2'b11, 3'd4, 3'd0, 0);
    applyStimulus(2'b01, 3'd1, 3'd2, 0);
    applyStimulus(2'b10, 3'd7, 3'd7, 1);

    $display("[TB] reset during multiply");
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_a     = 3'd7;
    req_b     = 3'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort req_ready", req_ready, 1);
    checkOutput("abort rsp_valid", rsp_valid, 0);
    checkOutput("abort result", rsp_result, 0);
    checkOutput("abort carry", rsp_carry, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("no response after abort", rsp_valid, 0);
    end
    applyStimulus(2'b00, 3'd1, 3'd2, 0);

    $display("[TB] random operations");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
